// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 2-bit ALU between two requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_STATS_EN to add saturating per-requester grant counters gnt_cnt0/gnt_cnt1.
module alu_arbiter #(
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [1:0] req0_a,
  input  logic [1:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [1:0] req1_a,
  input  logic [1:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [1:0] rsp_result,
  output logic       rsp_overflow
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, next_state;
  logic       ptr;
  logic       gnt0, gnt1;
  logic       cap_id;
  logic [1:0] cap_a, cap_b;
  logic [2:0] cap_op;
  logic [1:0] alu_res;
  logic       alu_ov;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Grants are only possible in IDLE; ptr picks the winner when both ask.
  always_comb begin
    next_state = state;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    case (state)
      IDLE: begin
        gnt0 = req0_valid && (!req1_valid || !ptr);
        gnt1 = req1_valid && (!req0_valid || ptr);
        if (gnt0 || gnt1) next_state = EXEC;
      end
      EXEC:    next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Ready is gated by rst_n so it drops the instant reset is asserted.
  assign req0_ready = gnt0 & rst_n;
  assign req1_ready = gnt1 & rst_n;
  assign rsp_valid  = (state == RESP);

  always_comb begin
    alu_res = 2'b00;
    alu_ov  = 1'b0;
    case (cap_op)
      3'b000:         {alu_ov, alu_res} = {1'b0, cap_a} + {1'b0, cap_b};
      3'b001:         alu_res = cap_a - cap_b;
      3'b010:         {alu_ov, alu_res} = {1'b0, cap_a} + 3'd1;
      3'b011, 3'b100: alu_res = cap_a & cap_b;
      3'b101:         alu_res = cap_a | cap_b;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= 1'b0;
      cap_id       <= 1'b0;
      cap_a        <= 2'b00;
      cap_b        <= 2'b00;
      cap_op       <= 3'b000;
      rsp_id       <= 1'b0;
      rsp_result   <= 2'b00;
      rsp_overflow <= 1'b0;
    end else begin
      if (gnt0 || gnt1) begin
        ptr    <= !gnt1;
        cap_id <= gnt1;
        cap_a  <= gnt1 ? req1_a  : req0_a;
        cap_b  <= gnt1 ? req1_b  : req0_b;
        cap_op <= gnt1 ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        rsp_id       <= cap_id;
        rsp_result   <= alu_res;
        rsp_overflow <= alu_ov;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && (gnt_cnt0 != '1)) gnt_cnt0 <= gnt_cnt0 + CntOne;
      if (gnt1 && (gnt_cnt1 != '1)) gnt_cnt1 <= gnt_cnt1 + CntOne;
    end
  end
`else
  logic [CNT_W-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: grant order, latency, ALU codes, stall and reset.
// Counter saturation checks are compiled in only when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [1:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_overflow;
  logic [1:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [1:0] gnt_cnt0, gnt_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_overflow(rsp_overflow)
`ifdef ALU_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit id, input logic valid, input logic [1:0] a,
                               input logic [1:0] b, input logic [2:0] op);
    if (id) begin
      req1_valid = valid; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = valid; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // Single-requester transaction with bounded waits on ready and rsp_valid.
  task automatic runOp(input bit id, input logic [1:0] a, input logic [1:0] b, input logic [2:0] op,
                       input logic [1:0] exp_res, input logic exp_ov, input string tag);
    int waited;
    applyStimulus(id, 1'b1, a, b, op);
    #1;
    waited = 0;
    while (!(id ? req1_ready : req0_ready) && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_ready"}, {7'd0, (id ? req1_ready : req0_ready)}, 8'd1);
    tick();
    applyStimulus(id, 1'b0, 2'b00, 2'b00, 3'b000);
    waited = 0;
    while (!rsp_valid && waited < 10) begin
      tick();
      waited++;
    end
    checkOutput({tag, "_valid"}, {7'd0, rsp_valid}, 8'd1);
    checkOutput({tag, "_id"}, {7'd0, rsp_id}, {7'd0, id});
    checkOutput({tag, "_res"}, {6'd0, rsp_result}, {6'd0, exp_res});
    checkOutput({tag, "_ov"}, {7'd0, rsp_overflow}, {7'd0, exp_ov});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_rsp_valid", {7'd0, rsp_valid}, 8'd0);
    checkOutput("rst_ready0", {7'd0, req0_ready}, 8'd0);
    checkOutput("rst_ready1", {7'd0, req1_ready}, 8'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 3'b000);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 3'b000);

    // Basic add with overflow: 3 + 1 = 4 -> result 00, overflow 1, latency 2.
    applyStimulus(1'b0, 1'b1, 2'b11, 2'b01, 3'b000);
    doReset();
    checkOutput("rst_result", {6'd0, rsp_result}, 8'd0);
    checkOutput("rst_id", {7'd0, rsp_id}, 8'd0);
    #1;
    checkOutput("t1_ready0", {7'd0, req0_ready}, 8'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 3'b000);
    checkOutput("t1_exec_ready0", {7'd0, req0_ready}, 8'd0);
    checkOutput("t1_exec_valid", {7'd0, rsp_valid}, 8'd0);
    tick();
    checkOutput("t1_valid", {7'd0, rsp_valid}, 8'd1);
    checkOutput("t1_id", {7'd0, rsp_id}, 8'd0);
    checkOutput("t1_res", {6'd0, rsp_result}, 8'd0);
    checkOutput("t1_ov", {7'd0, rsp_overflow}, 8'd1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("t1_done", {7'd0, rsp_valid}, 8'd0);

    // Both valid from reset: req0 wins, req1 stalls through a held response.
    doReset();
    applyStimulus(1'b0, 1'b1, 2'b10, 2'b01, 3'b101);
    applyStimulus(1'b1, 1'b1, 2'b00, 2'b01, 3'b001);
    #1;
    checkOutput("t2_ready0", {7'd0, req0_ready}, 8'd1);
    checkOutput("t2_ready1", {7'd0, req1_ready}, 8'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 3'b000);
    checkOutput("t2_exec_ready1", {7'd0, req1_ready}, 8'd0);
    tick();
    checkOutput("t2_valid", {7'd0, rsp_valid}, 8'd1);
    checkOutput("t2_res", {6'd0, rsp_result}, 8'd3);
    checkOutput("t2_id", {7'd0, rsp_id}, 8'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("t2_hold_valid", {7'd0, rsp_valid}, 8'd1);
      checkOutput("t2_hold_res", {5'd0, rsp_id, rsp_result}, 8'd3);
      checkOutput("t2_hold_ready1", {7'd0, req1_ready}, 8'd0);
    end
    rsp_ready = 1'b1;
    #1;
    checkOutput("t2_accept_ready1", {7'd0, req1_ready}, 8'd0);
    tick();
    checkOutput("t2_idle_valid", {7'd0, rsp_valid}, 8'd0);
    checkOutput("t2_idle_ready1", {7'd0, req1_ready}, 8'd1);
    tick();
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 3'b000);
    checkOutput("t2_exec2_valid", {7'd0, rsp_valid}, 8'd0);
    tick();
    checkOutput("t2_r1_valid", {7'd0, rsp_valid}, 8'd1);
    checkOutput("t2_r1_id", {7'd0, rsp_id}, 8'd1);
    checkOutput("t2_r1_res", {6'd0, rsp_result}, 8'd3);
    checkOutput("t2_r1_ov", {7'd0, rsp_overflow}, 8'd0);
    tick();
    rsp_ready = 1'b0;
    checkOutput("t2_r1_done", {7'd0, rsp_valid}, 8'd0);

    // ALU codes, alternating requesters.
    runOp(1'b0, 2'b11, 2'b11, 3'b110, 2'b00, 1'b0, "op110");
    runOp(1'b1, 2'b11, 2'b11, 3'b111, 2'b00, 1'b0, "op111");
    runOp(1'b0, 2'b11, 2'b00, 3'b010, 2'b00, 1'b1, "op010");
    runOp(1'b1, 2'b01, 2'b01, 3'b000, 2'b10, 1'b0, "op000");
    runOp(1'b1, 2'b01, 2'b10, 3'b001, 2'b11, 1'b0, "op001");
    runOp(1'b0, 2'b11, 2'b10, 3'b011, 2'b10, 1'b0, "op011");
    runOp(1'b0, 2'b01, 2'b11, 3'b100, 2'b01, 1'b0, "op100");
    runOp(1'b1, 2'b01, 2'b10, 3'b101, 2'b11, 1'b0, "op101");

    // Reset during EXEC after a req0 grant (pointer now 1) discards the op.
    applyStimulus(1'b0, 1'b1, 2'b01, 2'b01, 3'b000);
    #1;
    checkOutput("t4_ready0", {7'd0, req0_ready}, 8'd1);
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("t4_rst_out", {3'd0, rsp_valid, rsp_id, rsp_result, rsp_overflow}, 8'd0);
    checkOutput("t4_rst_rdy", {6'd0, req0_ready, req1_ready}, 8'd0);
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 3'b000);
    tick();
    tick();
    checkOutput("t4_no_rsp", {7'd0, rsp_valid}, 8'd0);
    applyStimulus(1'b0, 1'b1, 2'b10, 2'b01, 3'b000);
    applyStimulus(1'b1, 1'b1, 2'b01, 2'b01, 3'b000);
    #1;
    checkOutput("t4_ptr0_r0", {7'd0, req0_ready}, 8'd1);
    checkOutput("t4_ptr0_r1", {7'd0, req1_ready}, 8'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 2'b00, 3'b000);
    applyStimulus(1'b1, 1'b0, 2'b00, 2'b00, 3'b000);

`ifdef ALU_ARB_STATS_EN
    doReset();
    checkOutput("cnt_rst", {4'd0, gnt_cnt0, gnt_cnt1}, 8'd0);
    runOp(1'b0, 2'b01, 2'b01, 3'b000, 2'b10, 1'b0, "cnt_g1");
    checkOutput("cnt0_one", {6'd0, gnt_cnt0}, 8'd1);
    for (int i = 0; i < 4; i++) runOp(1'b0, 2'b01, 2'b01, 3'b000, 2'b10, 1'b0, "cnt_gn");
    checkOutput("cnt0_sat", {6'd0, gnt_cnt0}, 8'd3);
    checkOutput("cnt1_zero", {6'd0, gnt_cnt1}, 8'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of the per-requester grant counters (used only with ALU_ARB_STATS_EN).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Ports: req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 Ports: req0_ready / req1_ready  output  1  operands of requester N captured this cycle.
REQ-006 Ports: req0_a, req0_b, req1_a, req1_b  input  2  operands of requester N.
REQ-007 Ports: req0_op / req1_op  input  3  operation code of requester N.
REQ-008 Port: rsp_valid  output  1  response held on rsp_* outputs.
REQ-009 Port: rsp_ready  input  1  consumer accepts the response.
REQ-010 Port: rsp_id  output  1  requester that owns the response (0 or 1).
REQ-011 Port: rsp_result  output  2  ALU result.
REQ-012 Port: rsp_overflow  output  1  ALU carry/overflow flag.
REQ-013 Ports: gnt_cnt0 / gnt_cnt1  output  CNT_W  grant counts; present only with ALU_ARB_STATS_EN.

Function
REQ-014 The block shall share one 2-bit ALU between two requesters using a three-state FSM: IDLE, EXEC, RESP.
REQ-015 IDLE: if any reqN_valid is high, the block shall grant one requester, pulse its reqN_ready for that cycle, capture its a/b/op and id, and go to EXEC; otherwise it stays in IDLE.
REQ-016 Arbitration shall be round-robin: a priority pointer (reset 0) selects the favoured requester on simultaneous valids, and flips to the other requester after every grant.
REQ-017 A single valid requester shall be granted regardless of the pointer; the pointer still flips to the non-granted requester.
REQ-018 EXEC: the block shall compute on the captured operands, register result, overflow and id into rsp_*, and go to RESP; rsp_valid rises on the following cycle, so latency is 2 cycles from grant.
REQ-019 ALU codes: 000 {overflow,result}=a+b; 001 result=a-b mod 4, overflow 0; 010 {overflow,result}=a+1; 011 and 100 result=a&b, overflow 0; 101 result=a|b, overflow 0; 110/111 result 0, overflow 0.
REQ-020 RESP: rsp_valid shall stay high and all rsp_* outputs stay stable until the cycle rsp_ready is high; the block then drops rsp_valid and returns to IDLE.
REQ-021 No grant shall occur in EXEC or RESP; both reqN_ready shall be low there; a requester shall hold valid and operands until its ready pulse.
REQ-022 Back-to-back throughput shall be at most one operation per 3 cycles (IDLE, EXEC, RESP with rsp_ready already high).
REQ-023 rsp_ready sampled outside RESP shall have no effect.

Reset
REQ-024 Assertion of rst_n low shall immediately force state IDLE, pointer 0, rsp_valid 0, rsp_id 0, rsp_result 00, rsp_overflow 0, req0_ready and req1_ready 0, gnt counters 0.
REQ-025 Reset in EXEC or RESP shall discard the in-flight operation without a response; after release the first grant follows REQ-015/016 from pointer 0.

Configuration
REQ-026 With macro ALU_ARB_STATS_EN defined, gnt_cnt0/gnt_cnt1 shall exist and increment by one on each grant to that requester, saturating at 2^CNT_W-1.
REQ-027 Without ALU_ARB_STATS_EN, the counters and their ports shall be absent and all other behaviour identical.

Verification
REQ-028 Reset, req0 only: a=11,b=01,op=000 -> req0_ready pulses one cycle, 2 cycles later rsp_valid=1, rsp_id=0, result=00, overflow=1.
REQ-029 Both valid from reset: req0 op=101 a=10 b=01, req1 op=001 a=00 b=01 -> req0 granted first (result 11); after its rsp_ready, req1 granted (result 11, overflow 0, rsp_id=1).
REQ-030 rsp_ready held low 5 cycles in RESP with req1 valid -> rsp_* stable, req1_ready stays 0 until response accepted.
REQ-031 op=110 and op=111 with a=11,b=11 -> result 00, overflow 0; op=010 with a=11 -> result 00, overflow 1.
REQ-032 rst_n asserted in EXEC -> outputs reset values immediately, no response emitted; next grant uses pointer 0.
REQ-033 With ALU_ARB_STATS_EN and CNT_W=2: five grants to req0 -> gnt_cnt0 saturates at 3, gnt_cnt1 stays 0.
